// File: rtl/ex_muldiv_if.sv
// ---------------------------------------------------------------------------
// ex_muldiv_if : issue/result bundle between the EX stage and the HI/LO
//                multiply/divide unit.
//
//   master (EX stage)  drives : start, func, isSign, A, B, flush
//                      reads  : busy, done, divByZero, HI, LO
//   slave  (ex_muldiv) is the mirror image.
// ---------------------------------------------------------------------------
interface ex_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       func;
  logic             isSign;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             flush;
  logic             busy;
  logic             done;
  logic             divByZero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, func, isSign, A, B, flush,
    input  busy, done, divByZero, HI, LO
  );

  modport slave (
    input  start, func, isSign, A, B, flush,
    output busy, done, divByZero, HI, LO
  );
endinterface

// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv : multi-cycle HI/LO multiply/divide unit for the EX stage.
//
// Ports
//   clk   : clock
//   rst   : synchronous active-high reset
//   md    : ex_muldiv_if.slave
//             start/func/isSign/A/B : operation issue (accepted only in IDLE)
//             flush                 : cancels the in-flight operation
//             busy                  : registered, operation in flight
//             done / divByZero      : one-cycle pulses after commit
//             HI / LO               : architectural registers (direct)
//
// Operations: MULT (MUL_STAGES edges), DIV (WIDTH step edges + 1 fix edge),
// DIV by zero (1 edge), MTHI/MTLO (same edge, no busy, no done).
//
// Optional feature macro: MD_MADD_EN
//   defined   : func 101/110 perform MADD/MSUB into {HI,LO}
//   undefined : func 101/110 are ignored, no accumulate hardware
// ---------------------------------------------------------------------------
module ex_muldiv #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 3
) (
  input logic         clk,
  input logic         rst,
  ex_muldiv_if.slave  md
);

  localparam int CNT_W = $clog2(WIDTH + MUL_STAGES + 1);

  localparam logic [2:0] F_MULT = 3'b001;
  localparam logic [2:0] F_DIV  = 3'b010;
  localparam logic [2:0] F_MTHI = 3'b011;
  localparam logic [2:0] F_MTLO = 3'b100;
`ifdef MD_MADD_EN
  localparam logic [2:0] F_MADD = 3'b101;
  localparam logic [2:0] F_MSUB = 3'b110;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DZ
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
`ifdef MD_MADD_EN
  logic               madd_q, madd_d;
  logic               msub_q, msub_d;
`endif

  // -------------------------------------------------------------------------
  // Multiplier: product of the latched operands, then a register chain so
  // the synthesis tool can retime the multiplier across MUL_STAGES-1 stages.
  // Operands are stable for the whole MUL state, so the last stage always
  // holds the correct product by the commit edge.
  // -------------------------------------------------------------------------
  logic [2*WIDTH-1:0] a_ext, b_ext, prod_comb, prod_final, mul_result;

  assign a_ext     = sign_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign b_ext     = sign_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign prod_comb = a_ext * b_ext;

  generate
    if (MUL_STAGES == 1) begin : g_prod_comb
      assign prod_final = prod_comb;
    end else begin : g_prod_pipe
      logic [2*WIDTH-1:0] pipe_q [MUL_STAGES-1];
      logic [2*WIDTH-1:0] pipe_d [MUL_STAGES-1];

      always_comb begin
        pipe_d[0] = prod_comb;
        for (int i = 1; i < MUL_STAGES - 1; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        for (int i = 0; i < MUL_STAGES - 1; i++) begin
          if (rst) pipe_q[i] <= '0;
          else     pipe_q[i] <= pipe_d[i];
        end
      end

      assign prod_final = pipe_q[MUL_STAGES-2];
    end
  endgenerate

`ifdef MD_MADD_EN
  always_comb begin
    mul_result = prod_final;
    if (madd_q)      mul_result = {hi_q, lo_q} + prod_final;
    else if (msub_q) mul_result = {hi_q, lo_q} - prod_final;
  end
`else
  assign mul_result = prod_final;
`endif

  // -------------------------------------------------------------------------
  // Divider datapath: restoring radix-2 on magnitudes. quo_q starts as |A|
  // and is shifted out MSB-first while quotient bits shift in at the LSB.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] in_mag_a, mag_b;
  logic [WIDTH:0]   rem_sh, diff;
  logic             neg_quo, neg_rem;

  assign in_mag_a = (md.isSign && md.A[WIDTH-1]) ? -md.A : md.A;
  assign mag_b    = (sign_q && b_q[WIDTH-1]) ? -b_q : b_q;
  assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
  assign diff     = rem_sh - {1'b0, mag_b};
  assign neg_quo  = sign_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign neg_rem  = sign_q & a_q[WIDTH-1];

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
`ifdef MD_MADD_EN
    madd_d  = madd_q;
    msub_d  = msub_q;
`endif

    case (state_q)
      S_IDLE: begin
        // Operand registers track the inputs while idle; the value captured
        // at the accepting edge is what the operation then works on.
        a_d    = md.A;
        b_d    = md.B;
        sign_d = md.isSign;
        cnt_d  = '0;
        rem_d  = '0;
        quo_d  = in_mag_a;
        busy_d = 1'b0;
        if (md.start) begin
          case (md.func)
            F_MULT: begin
              state_d = S_MUL;
              busy_d  = 1'b1;
`ifdef MD_MADD_EN
              madd_d  = 1'b0;
              msub_d  = 1'b0;
`endif
            end
`ifdef MD_MADD_EN
            F_MADD: begin
              state_d = S_MUL;
              busy_d  = 1'b1;
              madd_d  = 1'b1;
              msub_d  = 1'b0;
            end
            F_MSUB: begin
              state_d = S_MUL;
              busy_d  = 1'b1;
              madd_d  = 1'b0;
              msub_d  = 1'b1;
            end
`endif
            F_DIV: begin
              state_d = (md.B == '0) ? S_DZ : S_DIV;
              busy_d  = 1'b1;
            end
            F_MTHI:  hi_d = md.A;
            F_MTLO:  lo_d = md.A;
            default: ;
          endcase
        end
      end

      S_MUL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_STAGES - 1)) begin
          {hi_d, lo_d} = mul_result;
          done_d       = 1'b1;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end
      end

      S_DIV: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (diff[WIDTH]) begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end

      S_FIX: begin
        // MIN / -1 falls out naturally: |MIN| negates back to MIN.
        lo_d    = neg_quo ? -quo_q : quo_q;
        hi_d    = neg_rem ? -rem_q : rem_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      S_DZ: begin
        lo_d    = '1;
        hi_d    = a_q;
        done_d  = 1'b1;
        dz_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Flush overrides everything, including a same-cycle MTHI/MTLO and a
    // commit that would otherwise happen on this edge.
    if (md.flush) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      dz_d    = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
`ifdef MD_MADD_EN
      madd_q  <= 1'b0;
      msub_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
`ifdef MD_MADD_EN
      madd_q  <= madd_d;
      msub_q  <= msub_d;
`endif
    end
  end

  assign md.busy      = busy_q;
  assign md.done      = done_q;
  assign md.divByZero = dz_q;
  assign md.HI        = hi_q;
  assign md.LO        = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv : bench for ex_muldiv (WIDTH=32, MUL_STAGES=3). Directed
// vector table, hand-written flush/reset sequences, then random operations
// checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_ex_muldiv;

  localparam int W  = 32;
  localparam int MS = 3;
`ifdef MD_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  localparam logic [2:0] F_NONE = 3'd0;
  localparam logic [2:0] F_MULT = 3'd1;
  localparam logic [2:0] F_DIV  = 3'd2;
  localparam logic [2:0] F_MTHI = 3'd3;
  localparam logic [2:0] F_MTLO = 3'd4;
  localparam logic [2:0] F_MADD = 3'd5;
  localparam logic [2:0] F_MSUB = 3'd6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_muldiv_if #(.WIDTH(W)) md_if ();

  ex_muldiv #(.WIDTH(W), .MUL_STAGES(MS)) dut (
    .clk (clk),
    .rst (rst),
    .md  (md_if)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] hi_m, lo_m;

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          busy;
    logic        done;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  function automatic vec_t mk(input string nm, input logic [2:0] f, input logic s,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] hi, input logic [31:0] lo,
                              input logic dz, input int busy, input logic done);
    vec_t v;
    v.name = nm; v.f = f; v.s = s; v.a = a; v.b = b;
    v.hi = hi; v.lo = lo; v.dz = dz; v.busy = busy; v.done = done;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference model: architectural effect of one accepted operation.
  function automatic void model(input logic [2:0] f, input logic s,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] hi0, input logic [31:0] lo0,
                                output logic [31:0] hi1, output logic [31:0] lo1,
                                output logic dz, output int busy, output logic done);
    logic [63:0] p, acc, ua, ub;
    longint sa, sb, sq, sr;
    logic [63:0] uq, ur;
    hi1 = hi0; lo1 = lo0; dz = 1'b0; busy = 0; done = 1'b0;
    acc = {hi0, lo0};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = 64'(sa * sb);
    end else begin
      ua = {32'd0, a};
      ub = {32'd0, b};
      p  = ua * ub;
    end
    if (f == F_MULT || (MADD_EN && (f == F_MADD || f == F_MSUB))) begin
      if (f == F_MADD)      acc = acc + p;
      else if (f == F_MSUB) acc = acc - p;
      else                  acc = p;
      hi1 = acc[63:32]; lo1 = acc[31:0];
      busy = MS; done = 1'b1;
    end else if (f == F_DIV) begin
      done = 1'b1;
      if (b == 32'd0) begin
        hi1 = a; lo1 = 32'hFFFF_FFFF; dz = 1'b1; busy = 1;
      end else begin
        busy = W + 1;
        if (s) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          sq = sa / sb;
          sr = sa % sb;
          lo1 = sq[31:0]; hi1 = sr[31:0];
        end else begin
          ua = {32'd0, a};
          ub = {32'd0, b};
          uq = ua / ub;
          ur = ua % ub;
          lo1 = uq[31:0]; hi1 = ur[31:0];
        end
      end
    end else if (f == F_MTHI) begin
      hi1 = a;
    end else if (f == F_MTLO) begin
      lo1 = a;
    end
  endfunction

  // Issue one operation and check its whole lifetime. poke>0 re-asserts
  // start (MTHI 0xBEEF) on that busy cycle; it must be ignored.
  task automatic do_op(input string nm, input logic [2:0] f, input logic s,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edz, input int ebusy, input logic edone,
                       input int poke);
    int   n;
    logic early;
    @(negedge clk);
    md_if.start = 1'b1; md_if.func = f; md_if.isSign = s; md_if.A = a; md_if.B = b;
    @(negedge clk);
    md_if.start  = 1'b0;
    md_if.func   = 3'($urandom_range(0, 6));
    md_if.A      = $urandom;
    md_if.B      = $urandom;
    md_if.isSign = 1'($urandom);
    n = 0; early = 1'b0;
    while (md_if.busy === 1'b1 && n < 200) begin
      if (md_if.done !== 1'b0) early = 1'b1;
      n++;
      if (n == poke) begin
        md_if.start = 1'b1; md_if.func = F_MTHI; md_if.A = 32'h0000_BEEF;
      end else begin
        md_if.start = 1'b0;
      end
      @(negedge clk);
    end
    md_if.start = 1'b0;
    chk({nm, "_busy_cycles"}, 64'(n), 64'(ebusy));
    chk({nm, "_done_early"}, {63'd0, early}, 64'd0);
    chk({nm, "_done"}, {63'd0, md_if.done}, {63'd0, edone});
    chk({nm, "_dz"}, {63'd0, md_if.divByZero}, {63'd0, edz});
    chk({nm, "_hi"}, {32'd0, md_if.HI}, {32'd0, ehi});
    chk({nm, "_lo"}, {32'd0, md_if.LO}, {32'd0, elo});
    $display("op %s func=%0d sign=%0d A=%h B=%h busy=%0d HI=%h LO=%h", nm, f, s, a, b,
             n, md_if.HI, md_if.LO);
    @(negedge clk);
    chk({nm, "_done_pulse_end"}, {62'd0, md_if.done, md_if.divByZero}, 64'd0);
  endtask

  task automatic rand_op(input int idx);
    logic [2:0]  f;
    logic        s, edz, edone;
    logic [31:0] a, b, ehi, elo;
    int          ebusy;
    f = 3'($urandom_range(0, 6));
    s = 1'($urandom);
    a = $urandom;
    b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
    if ($urandom_range(0, 9) == 0) begin
      a = 32'h8000_0000; b = 32'hFFFF_FFFF;
    end
    if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
    model(f, s, a, b, hi_m, lo_m, ehi, elo, edz, ebusy, edone);
    do_op($sformatf("rnd%0d", idx), f, s, a, b, ehi, elo, edz, ebusy, edone, 0);
    hi_m = ehi; lo_m = elo;
  endtask

  initial begin
    int   seen;
    logic [31:0] mhi, mlo;
    logic        mdz, mdone;
    int          mbusy;

    md_if.start = 1'b0; md_if.func = F_NONE; md_if.isSign = 1'b0;
    md_if.A = '0; md_if.B = '0; md_if.flush = 1'b0;

    vt[0]  = mk("mult_s_neg3x7", F_MULT, 1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, MS, 1);
    vt[1]  = mk("div_u_100_7", F_DIV, 0, 32'd100, 32'd7, 32'd2, 32'd14, 0, W + 1, 1);
    vt[2]  = mk("div_s_neg7_2", F_DIV, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, W + 1, 1);
    vt[3]  = mk("div_s_min_m1", F_DIV, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0, W + 1, 1);
    vt[4]  = mk("div_5_by_0", F_DIV, 0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, 1, 1);
    vt[5]  = mk("div_s_neg_by_0", F_DIV, 1, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1, 1, 1);
    vt[6]  = mk("mthi_0", F_MTHI, 0, 32'd0, 32'd9, 32'd0, 32'hFFFF_FFFF, 0, 0, 0);
`ifdef MD_MADD_EN
    vt[7]  = mk("madd_u_1x1", F_MADD, 0, 32'd1, 32'd1, 32'd1, 32'd0, 0, MS, 1);
    vt[8]  = mk("msub_u_1x1", F_MSUB, 0, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 0, MS, 1);
`else
    vt[7]  = mk("madd_u_1x1", F_MADD, 0, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 0, 0, 0);
    vt[8]  = mk("msub_u_1x1", F_MSUB, 0, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 0, 0, 0);
`endif
    vt[9]  = mk("mult_u_max", F_MULT, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 0, MS, 1);
    vt[10] = mk("div_s_7_negm2", F_DIV, 1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0, W + 1, 1);
    vt[11] = mk("mthi_1234", F_MTHI, 0, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFD, 0, 0, 0);
    vt[12] = mk("mtlo_5678", F_MTLO, 0, 32'h5678, 32'd0, 32'h1234, 32'h5678, 0, 0, 0);
    vt[13] = mk("func_none", F_NONE, 1, 32'h99, 32'h0, 32'h1234, 32'h5678, 0, 0, 0);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", {63'd0, md_if.busy}, 64'd0);
    chk("reset_done", {63'd0, md_if.done}, 64'd0);
    chk("reset_dz", {63'd0, md_if.divByZero}, 64'd0);
    chk("reset_hi", {32'd0, md_if.HI}, 64'd0);
    chk("reset_lo", {32'd0, md_if.LO}, 64'd0);

    for (int i = 0; i < NV; i++) begin
      do_op(vt[i].name, vt[i].f, vt[i].s, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo,
            vt[i].dz, vt[i].busy, vt[i].done, 0);
    end
    hi_m = 32'h1234; lo_m = 32'h5678;

    // start while busy is ignored; the DIV finishes normally
    do_op("div_mid_start", F_DIV, 0, 32'd9, 32'd3, 32'd0, 32'd3, 0, W + 1, 1, 5);
    do_op("restore_hi", F_MTHI, 0, 32'h1234, 32'd0, 32'h1234, 32'd3, 0, 0, 0, 0);
    do_op("restore_lo", F_MTLO, 0, 32'h5678, 32'd0, 32'h1234, 32'h5678, 0, 0, 0, 0);

    // flush mid-DIV together with start=MTHI: nothing accepted, nothing written
    @(negedge clk);
    md_if.start = 1'b1; md_if.func = F_DIV; md_if.isSign = 1'b0;
    md_if.A = 32'd9; md_if.B = 32'd3;
    @(negedge clk);
    md_if.start = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    chk("flush_pre_busy", {63'd0, md_if.busy}, 64'd1);
    md_if.start = 1'b1; md_if.func = F_MTHI; md_if.A = 32'hDEAD; md_if.flush = 1'b1;
    @(negedge clk);
    md_if.start = 1'b0; md_if.flush = 1'b0;
    chk("flush_busy", {63'd0, md_if.busy}, 64'd0);
    chk("flush_hi", {32'd0, md_if.HI}, 64'h1234);
    chk("flush_lo", {32'd0, md_if.LO}, 64'h5678);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (md_if.done !== 1'b0 || md_if.busy !== 1'b0) seen = 1;
      @(negedge clk);
    end
    chk("flush_no_done", 64'(seen), 64'd0);
    $display("op flush_mid_div HI=%h LO=%h", md_if.HI, md_if.LO);

    // flush exactly on the MULT commit edge
    md_if.start = 1'b1; md_if.func = F_MULT; md_if.isSign = 1'b0;
    md_if.A = 32'd2; md_if.B = 32'd3;
    @(negedge clk);
    md_if.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    md_if.flush = 1'b1;
    @(negedge clk);
    md_if.flush = 1'b0;
    chk("flush_commit_done", {63'd0, md_if.done}, 64'd0);
    chk("flush_commit_busy", {63'd0, md_if.busy}, 64'd0);
    chk("flush_commit_hi", {32'd0, md_if.HI}, 64'h1234);
    chk("flush_commit_lo", {32'd0, md_if.LO}, 64'h5678);
    $display("op flush_on_commit HI=%h LO=%h", md_if.HI, md_if.LO);

    // reset mid-DIV: everything cleared, no commit afterwards
    md_if.start = 1'b1; md_if.func = F_DIV; md_if.A = 32'd100; md_if.B = 32'd7;
    @(negedge clk);
    md_if.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", {63'd0, md_if.busy}, 64'd0);
    chk("rst_mid_hi", {32'd0, md_if.HI}, 64'd0);
    chk("rst_mid_lo", {32'd0, md_if.LO}, 64'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (md_if.done !== 1'b0) seen = 1;
      @(negedge clk);
    end
    chk("rst_mid_no_done", 64'(seen), 64'd0);
    $display("op reset_mid_div HI=%h LO=%h", md_if.HI, md_if.LO);
    hi_m = 32'd0; lo_m = 32'd0;

    // accumulate check from a known base through the model
    model(F_MTLO, 0, 32'hFFFF_FFFF, 32'd0, hi_m, lo_m, mhi, mlo, mdz, mbusy, mdone);
    do_op("mtlo_base", F_MTLO, 0, 32'hFFFF_FFFF, 32'd0, mhi, mlo, mdz, mbusy, mdone, 0);
    hi_m = mhi; lo_m = mlo;

    for (int i = 0; i < 60; i++) rand_op(i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
